// File: rtl/xfifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter.
// Holds the arbiter state encoding and the beat-counter sizing.
package xfifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  function automatic int cnt_w(input int maxlen);
    return $clog2(maxlen + 1);
  endfunction

endpackage

// File: rtl/xrr_pick.sv
// Combinational round-robin picker.
// Searches ptr+1, ptr+2, ... mod N and returns the first request found.
module xrr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/xfifo_wr_arb.sv
// Packet-locked round-robin arbiter feeding one FIFO write port.
// An owner keeps the port until its last beat or MAXLEN beats.
module xfifo_wr_arb
  import xfifo_arb_pkg::*;
#(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int MAXLEN = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_last,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic            we,
  output logic [DW-1:0]   din,
  input  logic            full_n,
  output logic [N-1:0]    grant,
  output logic            busy,
  output logic            len_err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = cnt_w(MAXLEN);

  state_t          state;
  logic [IW-1:0]   own;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            lock;
  logic            accept;
  logic            at_max;

  xrr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign lock   = (state == LOCK);
  assign accept = lock & req_valid[own] & full_n;
  assign at_max = (cnt == CW'(MAXLEN - 1));
  assign we     = accept;

  always_comb begin
    req_ready = '0;
    din       = '0;
    if (lock) begin
      req_ready[own] = full_n;
      din            = req_data[int'(own)*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      grant   <= '0;
      busy    <= 1'b0;
      len_err <= 1'b0;
      cnt     <= '0;
      own     <= '0;
      rr_ptr  <= IW'(N - 1);
    end else begin
      len_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            state <= LOCK;
            grant <= pick_oh;
            own   <= pick_idx;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        LOCK: begin
          if (accept) begin
            // Oversize packets are cut at MAXLEN and flagged.
            if (req_last[own] || at_max) begin
              state   <= IDLE;
              grant   <= '0;
              busy    <= 1'b0;
              cnt     <= '0;
              rr_ptr  <= own;
              len_err <= ~req_last[own];
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xfifo_wr_arb.sv
// Self-checking bench for xfifo_wr_arb.
// Directed packet scenarios plus a randomized run against a behavioural model.
module tb_xfifo_wr_arb;

  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int MAXLEN = 16;

  logic            clk  = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            we;
  logic [DW-1:0]   din;
  logic            full_n;
  logic [N-1:0]    grant;
  logic            busy;
  logic            len_err;

  int checks = 0;
  int errors = 0;

  // model: current owner (-1 = none), beats taken, last releaser
  int   m_own;
  int   m_beats;
  int   m_last;
  logic m_lenerr;

  xfifo_wr_arb #(
    .N      (N),
    .DW     (DW),
    .MAXLEN (MAXLEN)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .we        (we),
    .din       (din),
    .full_n    (full_n),
    .grant     (grant),
    .busy      (busy),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  task automatic mdl_reset();
    m_own    = -1;
    m_beats  = 0;
    m_last   = N - 1;
    m_lenerr = 1'b0;
  endtask

  task automatic mdl_edge();
    int j;
    m_lenerr = 1'b0;
    if (m_own < 0) begin
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (req_valid[j]) begin
          m_own   = j;
          m_beats = 0;
          break;
        end
      end
    end else if (req_valid[m_own] && full_n) begin
      m_beats++;
      if (req_last[m_own] || m_beats == MAXLEN) begin
        m_lenerr = !req_last[m_own];
        m_last   = m_own;
        m_own    = -1;
      end
    end
  endtask

  task automatic adv();
    mdl_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    full_n    = 1'b1;
    mdl_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    req_valid = '1;
    req_last  = '0;
    req_data  = '1;
    full_n    = 1'b1;
    mdl_reset();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL rst_grant got %b exp 0000", grant);
    end
    checks++;
    if (busy !== 1'b0 || len_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_len got %b%b exp 00", busy, len_err);
    end
    checks++;
    if (we !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_we_ready got %b %b exp 0 0000", we, req_ready);
    end
    @(posedge clk);
    #1;
    rstn      = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL rel_latency got %b exp 0000", grant);
    end
    adv();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_arb got %b/%b exp 0001/1", grant, busy);
    end
  endtask

  task automatic test_two_pkts();
    int b[N];
    logic [N-1:0] eg[9];
    logic ew[9];
    logic [DW-1:0] exp_w[$];
    eg    = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd4, 4'd4, 4'd4, 4'd0};
    ew    = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
    exp_w = '{8'h00, 8'h01, 8'h02, 8'h20, 8'h21, 8'h22};
    b     = '{default: 0};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      logic [N-1:0] acc;
      for (int i = 0; i < N; i += 2) begin
        req_valid[i]          = (b[i] < 3);
        req_last[i]           = (b[i] == 2);
        req_data[i*DW +: DW]  = {4'(i), 4'(b[i])};
      end
      @(negedge clk);
      checks++;
      if (grant !== eg[c]) begin
        errors++;
        $display("FAIL two_grant c=%0d got %b exp %b", c, grant, eg[c]);
      end
      checks++;
      if (we !== ew[c]) begin
        errors++;
        $display("FAIL two_we c=%0d got %b exp %b", c, we, ew[c]);
      end
      if (we === 1'b1) begin
        checks++;
        if (exp_w.size() == 0 || din !== exp_w[0]) begin
          errors++;
          $display("FAIL two_din c=%0d got %h", c, din);
        end
        if (exp_w.size() > 0) void'(exp_w.pop_front());
      end
      acc = req_valid & req_ready;
      adv();
      for (int i = 0; i < N; i++) if (acc[i]) b[i]++;
    end
    checks++;
    if (exp_w.size() != 0) begin
      errors++;
      $display("FAIL two_count missing %0d writes", exp_w.size());
    end
  endtask

  task automatic test_rr();
    int nw;
    logic [N-1:0] eg;
    nw = 0;
    do_reset();
    req_valid = '1;
    req_last  = '1;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'(i);
    for (int c = 0; c < 10; c++) begin
      eg = '0;
      if (c % 2 == 1) eg[((c - 1) / 2) % N] = 1'b1;
      @(negedge clk);
      checks++;
      if (grant !== eg) begin
        errors++;
        $display("FAIL rr_grant c=%0d got %b exp %b", c, grant, eg);
      end
      checks++;
      if (we !== 1'(c % 2)) begin
        errors++;
        $display("FAIL rr_we c=%0d got %b exp %0d", c, we, c % 2);
      end
      if (we === 1'b1) begin
        nw++;
        checks++;
        if (din !== 8'(((c - 1) / 2) % N)) begin
          errors++;
          $display("FAIL rr_din c=%0d got %h", c, din);
        end
      end
      adv();
    end
    checks++;
    if (nw != 5) begin
      errors++;
      $display("FAIL rr_writes got %0d exp 5", nw);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0010;
    req_data[1*DW +: DW] = 8'h10;
    @(negedge clk);
    adv();
    @(negedge clk);
    checks++;
    if (we !== 1'b1 || din !== 8'h10 || grant !== 4'b0010) begin
      errors++;
      $display("FAIL bp_beat0 got %b %h %b exp 1 10 0010", we, din, grant);
    end
    adv();
    req_data[1*DW +: DW] = 8'h11;
    @(negedge clk);
    adv();
    req_data[1*DW +: DW] = 8'h12;
    full_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (we !== 1'b0 || grant !== 4'b0010 || req_ready !== 4'b0000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold c=%0d got we=%b g=%b rdy=%b b=%b", c, we, grant, req_ready, busy);
      end
      adv();
    end
    full_n      = 1'b1;
    req_last[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (we !== 1'b1 || din !== 8'h12 || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_resume got %b %h %b exp 1 12 0010", we, din, req_ready);
    end
    adv();
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got %b/%b exp 0000/0", grant, busy);
    end
  endtask

  task automatic test_maxlen();
    int b;
    int nle;
    logic acc;
    b   = 0;
    nle = 0;
    do_reset();
    for (int c = 0; c < 19; c++) begin
      req_valid[3]          = (b < 20);
      req_data[3*DW +: DW]  = 8'(b);
      @(negedge clk);
      if (c >= 1 && c <= 16) begin
        checks++;
        if (we !== 1'b1 || din !== 8'(c - 1)) begin
          errors++;
          $display("FAIL max_beat c=%0d got %b %h exp 1 %h", c, we, din, 8'(c - 1));
        end
      end
      if (c == 17) begin
        checks++;
        if (len_err !== 1'b1 || grant !== 4'b0000 || we !== 1'b0) begin
          errors++;
          $display("FAIL max_cut got le=%b g=%b we=%b exp 1 0000 0", len_err, grant, we);
        end
      end
      if (c == 18) begin
        checks++;
        if (len_err !== 1'b0 || grant !== 4'b1000 || we !== 1'b1 || din !== 8'd16) begin
          errors++;
          $display("FAIL max_next got le=%b g=%b we=%b d=%h exp 0 1000 1 10", len_err, grant, we, din);
        end
      end
      if (len_err === 1'b1) nle++;
      acc = req_valid[3] & req_ready[3];
      adv();
      if (acc) b++;
    end
    checks++;
    if (nle != 1) begin
      errors++;
      $display("FAIL max_pulses got %0d exp 1", nle);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0100;
    req_data[0*DW +: DW] = 8'hA0;
    req_data[2*DW +: DW] = 8'h20;
    @(negedge clk);
    adv();
    @(negedge clk);
    checks++;
    if (we !== 1'b1 || grant !== 4'b0100) begin
      errors++;
      $display("FAIL rm_start got %b %b exp 1 0100", we, grant);
    end
    adv();
    req_data[2*DW +: DW] = 8'h21;
    @(negedge clk);
    adv();
    req_data[2*DW +: DW] = 8'h22;
    req_valid = 4'b0101;
    rstn      = 1'b0;
    #2;
    checks++;
    if (grant !== 4'b0000 || we !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rm_async got g=%b we=%b rdy=%b b=%b exp 0000 0 0000 0", grant, we, req_ready, busy);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (grant !== 4'b0000 || we !== 1'b0) begin
      errors++;
      $display("FAIL rm_held got %b %b exp 0000 0", grant, we);
    end
    rstn = 1'b1;
    mdl_reset();
    @(negedge clk);
    adv();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || we !== 1'b1 || din !== 8'hA0) begin
      errors++;
      $display("FAIL rm_after got %b %b %h exp 0001 1 a0", grant, we, din);
    end
  endtask

  task automatic test_drop_valid();
    do_reset();
    req_valid = 4'b0111;
    req_data[0*DW +: DW] = 8'h00;
    req_data[1*DW +: DW] = 8'h11;
    req_data[2*DW +: DW] = 8'h22;
    @(negedge clk);
    adv();
    @(negedge clk);
    adv();
    req_valid[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0001 || we !== 1'b0 || req_ready !== 4'b0001) begin
        errors++;
        $display("FAIL drop_gap c=%0d got g=%b we=%b rdy=%b exp 0001 0 0001", c, grant, we, req_ready);
      end
      adv();
    end
    req_valid[0] = 1'b1;
    req_last[0]  = 1'b1;
    req_data[0*DW +: DW] = 8'h01;
    @(negedge clk);
    checks++;
    if (we !== 1'b1 || din !== 8'h01) begin
      errors++;
      $display("FAIL drop_resume got %b %h exp 1 01", we, din);
    end
    adv();
    req_valid[0] = 1'b0;
    req_last[0]  = 1'b0;
    @(negedge clk);
    adv();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL drop_next got %b exp 0010", grant);
    end
  endtask

  task automatic test_random();
    logic [N-1:0]  eg;
    logic [N-1:0]  er;
    logic          ewe;
    logic [DW-1:0] edin;
    int            lp;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      lp = (c < 1500) ? 4 : 40;
      for (int i = 0; i < N; i++) begin
        req_valid[i]         = ($urandom_range(0, 3) != 0);
        req_last[i]          = ($urandom_range(0, lp - 1) == 0);
        req_data[i*DW +: DW] = DW'($urandom);
      end
      full_n = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      eg   = '0;
      er   = '0;
      ewe  = 1'b0;
      edin = '0;
      if (m_own >= 0) begin
        eg[m_own] = 1'b1;
        er[m_own] = full_n;
        ewe       = req_valid[m_own] & full_n;
        edin      = req_data[m_own*DW +: DW];
      end
      checks++;
      if (grant !== eg) begin
        errors++;
        $display("FAIL rnd_grant c=%0d got %b exp %b", c, grant, eg);
      end
      checks++;
      if (busy !== (m_own >= 0)) begin
        errors++;
        $display("FAIL rnd_busy c=%0d got %b exp %b", c, busy, m_own >= 0);
      end
      checks++;
      if (len_err !== m_lenerr) begin
        errors++;
        $display("FAIL rnd_len_err c=%0d got %b exp %b", c, len_err, m_lenerr);
      end
      checks++;
      if (we !== ewe) begin
        errors++;
        $display("FAIL rnd_we c=%0d got %b exp %b", c, we, ewe);
      end
      checks++;
      if (din !== edin) begin
        errors++;
        $display("FAIL rnd_din c=%0d got %h exp %h", c, din, edin);
      end
      checks++;
      if (req_ready !== er) begin
        errors++;
        $display("FAIL rnd_ready c=%0d got %b exp %b", c, req_ready, er);
      end
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_two_pkts();
    test_rr();
    test_backpressure();
    test_maxlen();
    test_reset_mid();
    test_drop_valid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/xfifo_wr_arb.md
XFIFO_WR_ARB -- requirements
Module: xfifo_wr_arb

Interface
REQ-001 Parameter N, default 4: number of write requesters sharing one FIFO write port; N>=2.
REQ-002 Parameter DW, default 8: data width; equals the FIFO DW.
REQ-003 Parameter MAXLEN, default 16: maximum beats per packet; MAXLEN>=2.
REQ-004 clk  in  1  single clock, the FIFO write clock.
REQ-005 rstn  in  1  reset; asynchronous assert, active-low.
REQ-006 req_valid  in  N  per-requester beat valid.
REQ-007 req_last  in  N  per-requester last beat of packet.
REQ-008 req_data  in  N*DW  per-requester data; requester i occupies bits [i*DW +: DW].
REQ-009 req_ready  out  N  per-requester beat accepted when valid&ready.
REQ-010 we  out  1  FIFO write enable.
REQ-011 din  out  DW  FIFO write data.
REQ-012 full_n  in  1  FIFO not-full.
REQ-013 grant  out  N  registered one-hot current owner; all-zero when idle.
REQ-014 busy  out  1  high in state LOCK.
REQ-015 len_err  out  1  one-cycle pulse on forced release of an oversize packet.

Function
REQ-016 FSM states SHALL be IDLE and LOCK only.
REQ-017 IDLE, no req_valid: remain IDLE, grant=0.
REQ-018 IDLE, any req_valid: at the clock edge, grant SHALL load the one-hot index of the first valid requester searching rr_ptr+1, rr_ptr+2, ... mod N; state->LOCK; beat count->0.
REQ-019 Grant latency SHALL be exactly 1 cycle from req_valid assertion in IDLE to grant/busy high.
REQ-020 LOCK: req_ready[g]=full_n for owner g; req_ready of every other requester SHALL be 0.
REQ-021 LOCK: we=req_valid[g]&full_n combinationally; din=req_data slice g; in IDLE we=0 and din=0.
REQ-022 Beat accepted iff LOCK & req_valid[g] & full_n; each accepted beat increments the beat count.
REQ-023 Accepted beat with req_last[g]=1: state->IDLE, rr_ptr->g, grant->0 at the next edge.
REQ-024 Accepted beat without last that would make the count equal MAXLEN: forced release identical to REQ-023, plus len_err=1 for the following cycle.
REQ-025 full_n=0 in LOCK: hold grant, count and state; no beat accepted.
REQ-026 One IDLE bubble cycle SHALL separate consecutive packets; the releasing requester has lowest priority at the next arbitration.
REQ-027 Beat counter width SHALL be $clog2(MAXLEN+1); it never wraps.
REQ-028 Owner dropping req_valid mid-packet SHALL NOT release the grant.

Reset
REQ-029 rstn low SHALL asynchronously force: state=IDLE, grant=0, busy=0, len_err=0, count=0, rr_ptr=N-1 (requester 0 wins first).
REQ-030 Reset mid-packet SHALL discard the packet; we and all req_ready SHALL be 0 while rstn=0.
REQ-031 The first arbitration SHALL occur at the first rising edge after rstn deasserts.

Structure
REQ-032 Shared package xfifo_arb_pkg SHALL hold the state enum (IDLE, LOCK).
REQ-033 One sub-module xrr_pick (combinational round-robin picker: req, rr_ptr -> one-hot, index, any) SHALL be used.

Verification
REQ-034 Reset, requesters 0 and 2 valid, 3-beat packets, full_n=1 -> grant=0001, 3 writes, bubble, grant=0100, 3 writes.
REQ-035 All four valid continuously, 1-beat packets -> grant order 0,1,2,3,0; one write per two cycles.
REQ-036 Owner 1 mid-packet, full_n=0 for 5 cycles -> we=0, grant stays 0010, no extra beat; resumes when full_n=1.
REQ-037 Requester 3 sends 20 beats, last never set, MAXLEN=16 -> 16 writes, len_err pulse 1 cycle, grant=0000, beat 17 in a new packet.
REQ-038 rstn asserted after beat 2 of a 4-beat packet from requester 2 -> grant=0 immediately, we=0; after release requester 0 wins if valid.
REQ-039 Owner drops req_valid for 3 cycles mid-packet while others valid -> grant unchanged, no writes in the gap.
